// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI command-port arbiter.
// A command word is {op[3:0], arg[7:0]}; op 4'hF is chip-select framing.
package qspi_pkg;

  localparam int unsigned CMD_W = 12;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned ARG_W = 8;

  localparam logic [OP_W-1:0] OP_DUMMY = 4'h0;
  localparam logic [OP_W-1:0] OP_WR_S  = 4'h1;
  localparam logic [OP_W-1:0] OP_RD_S  = 4'h2;
  localparam logic [OP_W-1:0] OP_WR_D  = 4'h4;
  localparam logic [OP_W-1:0] OP_RD_D  = 4'h5;
  localparam logic [OP_W-1:0] OP_WR_Q  = 4'h6;
  localparam logic [OP_W-1:0] OP_RD_Q  = 4'h7;
  localparam logic [OP_W-1:0] OP_CS    = 4'hF;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '{op: OP_DUMMY, arg: 8'hFF};
  localparam cmd_t CMD_REL  = '{op: OP_CS,    arg: 8'hFF};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    PASS  = 3'd2,
    REL   = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/qspi_rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module qspi_rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned OWN_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [OWN_W-1:0] idx,
  output logic             any
);

  int unsigned      j;
  logic [OWN_W-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j  = (32'(ptr) + i) % NREQ;
      jj = OWN_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/qspi_cmd_arbiter.sv
// Round-robin sharer of the single QSPI engine command port; wraps each
// granted burst in CS-assert / CS-release words and holds grant until idle.
module qspi_cmd_arbiter
  import qspi_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CS_W  = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OWN_W = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*CMD_W-1:0]  req_cmd,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*IDX_W-1:0]  req_cs,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   cmd_valid,
  output logic [CMD_W-1:0]       cmd_data,
  input  logic                   cmd_ready,
  input  logic                   eng_idle,
  output logic                   busy,
  output logic [OWN_W-1:0]       owner
);

  state_t           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cs_idx_q, cs_idx_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             drain_wait_q, drain_wait_d;

  logic [CMD_W-1:0] cmd_arr [NREQ];
  logic [IDX_W-1:0] cs_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_arr[i] = req_cmd[CMD_W*i +: CMD_W];
    assign cs_arr[i]  = req_cs[IDX_W*i +: IDX_W];
  end

  logic [NREQ-1:0]  pick_gnt;
  logic [OWN_W-1:0] pick_idx;
  logic             pick_any;

  qspi_rr_pick #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  cmd_t            own_word;
  cmd_t            sel_word;
  logic            own_valid;
  logic            own_last;
  logic            own_blocked;
  logic            own_accept;
  logic [CS_W-1:0] cs_mask;

  assign own_word    = cmd_t'(cmd_arr[owner_q]);
  assign own_valid   = req_valid[owner_q];
  assign own_last    = req_last[owner_q];
  // Requesters may not frame CS themselves; such words are swallowed.
  assign own_blocked = own_valid && (own_word.op == OP_CS);
  assign cs_mask     = ~(CS_W'(1) << cs_idx_q);
  assign sel_word    = '{op: OP_CS, arg: ARG_W'(cs_mask)};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    cs_idx_d     = cs_idx_q;
    grant_d      = grant_q;
    drain_wait_d = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = CMD_IDLE;
    req_ready    = '0;
    own_accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d  = pick_idx;
          cs_idx_d = cs_arr[pick_idx];
          grant_d  = pick_gnt;
          state_d  = SEL;
        end
      end
      SEL: begin
        cmd_valid = 1'b1;
        cmd_data  = sel_word;
        if (cmd_ready) state_d = PASS;
      end
      PASS: begin
        cmd_data           = own_word;
        cmd_valid          = own_valid && !own_blocked;
        req_ready[owner_q] = own_blocked ? 1'b1 : cmd_ready;
        own_accept         = own_valid && (own_blocked || cmd_ready);
        if (own_accept && own_last) state_d = REL;
      end
      REL: begin
        cmd_valid = 1'b1;
        cmd_data  = CMD_REL;
        if (cmd_ready) begin
          drain_wait_d = 1'b1;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        // First DRAIN cycle ignores a possibly stale idle from before REL.
        if (!drain_wait_q && eng_idle) begin
          grant_d  = '0;
          rr_ptr_d = OWN_W'((32'(owner_q) + 32'd1) % NREQ);
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      cs_idx_q     <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      drain_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      cs_idx_q     <= cs_idx_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      drain_wait_q <= drain_wait_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule
